// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and types for the UART receive path.
//   DBIT_DEF         default data word width
//   FIFO_ADDR_W_DEF  default FIFO address width
//   FIFO_DEPTH_DEF   derived default FIFO depth (2**FIFO_ADDR_W_DEF)
//   fifo_op_e        per-cycle FIFO operation, encoded as {push, pop}
package uart_pkg;

  localparam int unsigned DBIT_DEF        = 8;
  localparam int unsigned FIFO_ADDR_W_DEF = 4;
  localparam int unsigned FIFO_DEPTH_DEF  = 1 << FIFO_ADDR_W_DEF;

  typedef enum logic [1:0] {
    NOP      = 2'b00,
    POP      = 2'b01,
    PUSH     = 2'b10,
    PUSH_POP = 2'b11
  } fifo_op_e;

  // Folds the accepted push/pop qualifiers into one operation code.
  function automatic fifo_op_e fifo_op(input logic push, input logic pop);
    return fifo_op_e'({push, pop});
  endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: bus between the UART receiver / host side and uart_rx_fifo.
//   wr, w_data    push strobe and byte (receiver rx_done_tick / rx_dout)
//   rd            pop strobe from the consumer
//   clr_ovf       clears the sticky overflow flag
//   r_data        head entry (first-word-fall-through)
//   empty, full   occupancy flags
//   count         entries stored, 0..2**ADDR_W
//   overflow      sticky dropped-push flag
//   almost_full   count >= AF_THRESH (only with UART_RX_FIFO_WATERMARK_EN)
// Modports: master = producer/consumer side, slave = FIFO.
interface uart_rx_fifo_if #(
  parameter int unsigned DBIT   = 8,
  parameter int unsigned ADDR_W = 4
);

  logic              wr;
  logic [DBIT-1:0]   w_data;
  logic              rd;
  logic              clr_ovf;
  logic [DBIT-1:0]   r_data;
  logic              empty;
  logic              full;
  logic [ADDR_W:0]   count;
  logic              overflow;
`ifdef UART_RX_FIFO_WATERMARK_EN
  logic              almost_full;
`endif

  modport master (
    output wr, w_data, rd, clr_ovf,
    input  r_data, empty, full, count, overflow
`ifdef UART_RX_FIFO_WATERMARK_EN
    , input almost_full
`endif
  );

  modport slave (
    input  wr, w_data, rd, clr_ovf,
    output r_data, empty, full, count, overflow
`ifdef UART_RX_FIFO_WATERMARK_EN
    , output almost_full
`endif
  );

endinterface

// File: rtl/uart_fifo_ctrl.sv
// uart_fifo_ctrl: pointer, occupancy and overflow control for uart_rx_fifo.
// Optional feature macro: UART_RX_FIFO_WATERMARK_EN (adds almost_full).
//   clk, rst        clock, synchronous active-high reset
//   wr, rd          push / pop requests
//   clr_ovf         clears overflow (a same-cycle drop wins)
//   push_en         storage write enable at wr_ptr
//   wr_ptr, rd_ptr  storage pointers, wrap modulo 2**ADDR_W
//   count           registered occupancy, 0..2**ADDR_W
//   empty, full     decoded from count
//   overflow        sticky dropped-push flag
//   almost_full     registered (next count >= AF_THRESH), macro only
module uart_fifo_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned ADDR_W = FIFO_ADDR_W_DEF
`ifdef UART_RX_FIFO_WATERMARK_EN
  , parameter int unsigned AF_THRESH = 12
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic              rd,
  input  logic              clr_ovf,
  output logic              push_en,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic [ADDR_W-1:0] rd_ptr,
  output logic [ADDR_W:0]   count,
  output logic              empty,
  output logic              full,
  output logic              overflow
`ifdef UART_RX_FIFO_WATERMARK_EN
  , output logic            almost_full
`endif
);

  localparam logic [ADDR_W:0]   FULL_CNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
`ifdef UART_RX_FIFO_WATERMARK_EN
  localparam logic [ADDR_W:0]   AF_LVL   = (ADDR_W + 1)'(AF_THRESH);
`endif

  logic            push_ok;
  logic            pop_ok;
  logic            drop;
  fifo_op_e        op;
  logic [ADDR_W:0] count_nxt;

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);

  // A push into a full FIFO is still accepted when a pop frees the head slot
  // in the same cycle; a pop on empty is simply ignored.
  assign push_ok = wr & (~full | rd);
  assign pop_ok  = rd & ~empty;
  assign drop    = wr & full & ~rd;
  assign op      = fifo_op(push_ok, pop_ok);

  // Storage is not reset, so the write is suppressed during reset to keep
  // the reset-cycle byte from landing anywhere observable.
  assign push_en = push_ok & ~rst;

  always_comb begin
    count_nxt = count;
    case (op)
      PUSH:    count_nxt = count + CNT_ONE;
      POP:     count_nxt = count - CNT_ONE;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      overflow    <= 1'b0;
`ifdef UART_RX_FIFO_WATERMARK_EN
      almost_full <= 1'b0;
`endif
    end else begin
      case (op)
        PUSH: wr_ptr <= wr_ptr + PTR_ONE;
        POP:  rd_ptr <= rd_ptr + PTR_ONE;
        PUSH_POP: begin
          wr_ptr <= wr_ptr + PTR_ONE;
          rd_ptr <= rd_ptr + PTR_ONE;
        end
        default: ;
      endcase
      count <= count_nxt;
      if (drop) begin
        overflow <= 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
      end
`ifdef UART_RX_FIFO_WATERMARK_EN
      almost_full <= (count_nxt >= AF_LVL);
`endif
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side circular buffer behind the UART receiver.
// Captures a byte on each wr strobe and presents the oldest byte on r_data
// with first-word-fall-through reads. Dropped pushes set a sticky overflow.
// Optional feature macro: UART_RX_FIFO_WATERMARK_EN (adds almost_full).
//   clk   single clock
//   rst   synchronous active-high reset (pointers, count, flags; not storage)
//   bus   uart_rx_fifo_if.slave: wr, w_data, rd, clr_ovf in;
//         r_data, empty, full, count, overflow [, almost_full] out
// Parameters: DBIT data width, ADDR_W address width (depth 2**ADDR_W),
//             AF_THRESH almost-full level (used only with the macro).
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DBIT      = DBIT_DEF,
  parameter int unsigned ADDR_W    = FIFO_ADDR_W_DEF,
  parameter int unsigned AF_THRESH = 12
) (
  input logic            clk,
  input logic            rst,
  uart_rx_fifo_if.slave  bus
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DBIT-1:0]   mem [DEPTH];
  logic              push_en;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;

  uart_fifo_ctrl #(
    .ADDR_W    (ADDR_W)
`ifdef UART_RX_FIFO_WATERMARK_EN
    , .AF_THRESH (AF_THRESH)
`endif
  ) u_ctrl (
    .clk         (clk),
    .rst         (rst),
    .wr          (bus.wr),
    .rd          (bus.rd),
    .clr_ovf     (bus.clr_ovf),
    .push_en     (push_en),
    .wr_ptr      (wr_ptr),
    .rd_ptr      (rd_ptr),
    .count       (bus.count),
    .empty       (bus.empty),
    .full        (bus.full),
    .overflow    (bus.overflow)
`ifdef UART_RX_FIFO_WATERMARK_EN
    , .almost_full (bus.almost_full)
`endif
  );

  always_ff @(posedge clk) begin
    if (push_en) begin
      mem[wr_ptr] <= bus.w_data;
    end
  end

  // Head entry is driven straight from storage; stale while empty.
  assign bus.r_data = mem[rd_ptr];

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

  localparam int unsigned DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks = 0;
  int errors = 0;

  logic [7:0] sb[$];
  logic       m_ovf = 1'b0;

  always #5 clk = ~clk;

  uart_rx_fifo_if #(.DBIT(8), .ADDR_W(4)) bus ();

  uart_rx_fifo #(
    .DBIT      (8),
    .ADDR_W    (4),
    .AF_THRESH (12)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] act,
                          input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check_eq({tag, "_count"}, 32'(bus.count), 32'(sb.size()));
    check_eq({tag, "_empty"}, 32'(bus.empty), 32'(sb.size() == 0));
    check_eq({tag, "_full"}, 32'(bus.full), 32'(sb.size() == DEPTH));
    check_eq({tag, "_ovf"}, 32'(bus.overflow), 32'(m_ovf));
`ifdef UART_RX_FIFO_WATERMARK_EN
    check_eq({tag, "_af"}, 32'(bus.almost_full), 32'(sb.size() >= 12));
`endif
    if (sb.size() != 0) begin
      check_eq({tag, "_head"}, 32'(bus.r_data), 32'(sb[0]));
    end
  endtask

  // One clock of stimulus; the model decides acceptance from its own state.
  task automatic step(input logic w, input logic [7:0] d, input logic r,
                      input logic c);
    bit was_full;
    bit push_ok;
    bit pop_ok;
    @(negedge clk);
    bus.wr      = w;
    bus.w_data  = d;
    bus.rd      = r;
    bus.clr_ovf = c;
    #1;
    was_full = (sb.size() == DEPTH);
    push_ok  = w && (!was_full || r);
    pop_ok   = r && (sb.size() != 0);
    if (pop_ok) begin
      check_eq("pop_data", 32'(bus.r_data), 32'(sb[0]));
      void'(sb.pop_front());
    end
    if (push_ok) sb.push_back(d);
    if (w && was_full && !r) m_ovf = 1'b1;
    else if (c) m_ovf = 1'b0;
    @(posedge clk);
    #1;
    check_state("step");
  endtask

  task automatic do_reset(input logic w);
    @(negedge clk);
    rst         = 1'b1;
    bus.wr      = w;
    bus.w_data  = 8'hEE;
    bus.rd      = 1'b0;
    bus.clr_ovf = 1'b0;
    @(posedge clk);
    #1;
    rst    = 1'b0;
    bus.wr = 1'b0;
    sb.delete();
    m_ovf = 1'b0;
    check_state("reset");
  endtask

  initial begin
    bus.wr      = 1'b0;
    bus.w_data  = '0;
    bus.rd      = 1'b0;
    bus.clr_ovf = 1'b0;

    do_reset(1'b0);

    // Basic order
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    step(1'b1, 8'h3C, 1'b0, 1'b0);
    step(1'b1, 8'h7E, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Fill, overflow, drain, clear
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    step(1'b1, 8'hFF, 1'b0, 1'b0);
    step(1'b1, 8'hFE, 1'b0, 1'b1);   // drop and clear together: set wins
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // Push+pop while full
    for (int i = 0; i < 16; i++) step(1'b1, 8'h80 + 8'(i), 1'b0, 1'b0);
    step(1'b1, 8'h55, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Push+pop while empty, then rd on empty
    step(1'b1, 8'h99, 1'b1, 1'b0);
    check_eq("fwft_99", 32'(bus.r_data), 32'h99);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Wrap-around at occupancy 5
    for (int i = 0; i < 5; i++) step(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) step(1'b1, 8'h40 + 8'(i), 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

`ifdef UART_RX_FIFO_WATERMARK_EN
    // Watermark edge
    for (int i = 0; i < 12; i++) step(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 11; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
`endif

    // Mid-stream reset with overflow set and a wr in the reset cycle
    for (int i = 0; i < 18; i++) step(1'b1, 8'h20 + 8'(i), 1'b0, 1'b0);
    do_reset(1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 8'h66, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
